// File: rtl/mem_arbiter.sv
// Shared-RAM arbiter between an instruction cache (line reads) and a data cache
// (line refills and write-through words), with round-robin between the two caches.
module mem_arbiter #(
  parameter int LAT = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         ic_req,
  input  logic [31:0]  ic_addr,
  output logic         ic_done,
  output logic [127:0] ic_rdata,
  input  logic         dc_rd_req,
  input  logic         dc_wr_req,
  input  logic [31:0]  dc_addr,
  input  logic [31:0]  dc_wdata,
  output logic         dc_done,
  output logic [127:0] dc_rdata,
  output logic         mem_rd,
  output logic         mem_wr,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  input  logic [127:0] mem_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IC_RD,
    ST_DC_RD,
    ST_DC_WR,
    ST_DONE
  } state_e;

  localparam logic [2:0] LAST_CNT = 3'(LAT - 1);

  state_e         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic           last_dc_q, last_dc_d;
  logic           src_dc_q, src_dc_d;
  logic [31:0]    mem_addr_q, mem_addr_d;
  logic [31:0]    mem_wdata_q, mem_wdata_d;
  logic [127:0]   ic_rdata_q, ic_rdata_d;
  logic [127:0]   dc_rdata_q, dc_rdata_d;

  logic           dc_cand;
  logic           grant_dc;
  logic           grant_ic;
  logic           final_cycle;

  // The DC wins a contested slot only when the IC was served last.
  assign dc_cand     = dc_rd_req | dc_wr_req;
  assign grant_dc    = dc_cand & (~ic_req | ~last_dc_q);
  assign grant_ic    = ic_req & ~grant_dc;
  assign final_cycle = (cnt_q == LAST_CNT);

  // NOTE: every variable gets its hold value first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_dc_d   = last_dc_q;
    src_dc_d    = src_dc_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ic_rdata_d  = ic_rdata_q;
    dc_rdata_d  = dc_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_dc) begin
          src_dc_d  = 1'b1;
          last_dc_d = 1'b1;
          cnt_d     = 3'd0;
          if (dc_wr_req) begin
            state_d     = ST_DC_WR;
            mem_addr_d  = dc_addr;
            mem_wdata_d = dc_wdata;
          end else begin
            state_d    = ST_DC_RD;
            mem_addr_d = {dc_addr[31:4], 4'b0000};
          end
        end else if (grant_ic) begin
          src_dc_d   = 1'b0;
          last_dc_d  = 1'b0;
          cnt_d      = 3'd0;
          state_d    = ST_IC_RD;
          mem_addr_d = {ic_addr[31:4], 4'b0000};
        end
      end

      ST_IC_RD: begin
        cnt_d = cnt_q + 3'd1;
        if (final_cycle) begin
          state_d    = ST_DONE;
          ic_rdata_d = mem_rdata;
        end
      end

      ST_DC_RD: begin
        cnt_d = cnt_q + 3'd1;
        if (final_cycle) begin
          state_d    = ST_DONE;
          dc_rdata_d = mem_rdata;
        end
      end

      ST_DC_WR: begin
        cnt_d = cnt_q + 3'd1;
        if (final_cycle) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, matching real hardware.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      last_dc_q   <= 1'b1;
      src_dc_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      ic_rdata_q  <= 128'd0;
      dc_rdata_q  <= 128'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_dc_q   <= last_dc_d;
      src_dc_q    <= src_dc_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ic_rdata_q  <= ic_rdata_d;
      dc_rdata_q  <= dc_rdata_d;
    end
  end

  // Strobes and dones decode straight from the state register, so they are glitch-free
  // and fall to zero in the same cycle a reset is taken.
  assign mem_rd    = (state_q == ST_IC_RD) || (state_q == ST_DC_RD);
  assign mem_wr    = (state_q == ST_DC_WR);
  assign ic_done   = (state_q == ST_DONE) && !src_dc_q;
  assign dc_done   = (state_q == ST_DONE) &&  src_dc_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ic_rdata  = ic_rdata_q;
  assign dc_rdata  = dc_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-timeline reference model.
module tb_mem_arbiter;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic         ic_req;
  logic [31:0]  ic_addr;
  logic         ic_done;
  logic [127:0] ic_rdata;
  logic         dc_rd_req;
  logic         dc_wr_req;
  logic [31:0]  dc_addr;
  logic [31:0]  dc_wdata;
  logic         dc_done;
  logic [127:0] dc_rdata;
  logic         mem_rd;
  logic         mem_wr;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [127:0] mem_rdata;

  mem_arbiter #(.LAT(LAT)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .ic_req    (ic_req),
    .ic_addr   (ic_addr),
    .ic_done   (ic_done),
    .ic_rdata  (ic_rdata),
    .dc_rd_req (dc_rd_req),
    .dc_wr_req (dc_wr_req),
    .dc_addr   (dc_addr),
    .dc_wdata  (dc_wdata),
    .dc_done   (dc_done),
    .dc_rdata  (dc_rdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Reference model: k is the position inside the current transaction
  // (0 = idle, 1..LAT = access cycles, LAT+1 = done cycle).
  int           k;
  logic         m_dc, m_wr, m_last_dc;
  logic [31:0]  m_mem_addr, m_mem_wdata;
  logic [127:0] m_ic_rdata, m_dc_rdata;

  always @(posedge clk) begin
    logic [31:0] a;
    if (rstn) begin
      k = 0; m_dc = 1'b0; m_wr = 1'b0; m_last_dc = 1'b1;
      m_mem_addr = '0; m_mem_wdata = '0; m_ic_rdata = '0; m_dc_rdata = '0;
    end else if (k == 0) begin
      if (ic_req || dc_rd_req || dc_wr_req) begin
        m_dc      = (dc_rd_req || dc_wr_req) && (!ic_req || !m_last_dc);
        m_wr      = m_dc && dc_wr_req;
        m_last_dc = m_dc;
        a         = m_dc ? dc_addr : ic_addr;
        m_mem_addr = m_wr ? a : {a[31:4], 4'b0000};
        if (m_wr) m_mem_wdata = dc_wdata;
        k = 1;
      end
    end else if (k <= LAT) begin
      if (k == LAT && !m_wr) begin
        if (m_dc) m_dc_rdata = mem_rdata;
        else      m_ic_rdata = mem_rdata;
      end
      k = k + 1;
    end else begin
      k = 0;
    end
  end

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   ic_done_cyc = 0;
  int   dc_done_cyc = 0;
  logic seen_ic_done = 1'b0;
  logic seen_dc_done = 1'b0;
  logic done_log[$];
  logic rand_mode = 1'b0;
  logic auto_drop = 1'b1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_compare();
    logic acc;
    acc = (k >= 1) && (k <= LAT);
    check("mdl_mem_rd",    mem_rd,    acc && !m_wr);
    check("mdl_mem_wr",    mem_wr,    acc &&  m_wr);
    check("mdl_mem_addr",  mem_addr,  m_mem_addr);
    check("mdl_mem_wdata", mem_wdata, m_mem_wdata);
    check("mdl_ic_done",   ic_done,   (k == LAT + 1) && !m_dc);
    check("mdl_dc_done",   dc_done,   (k == LAT + 1) &&  m_dc);
    check("mdl_ic_rdata",  ic_rdata,  m_ic_rdata);
    check("mdl_dc_rdata",  dc_rdata,  m_dc_rdata);
    check("excl_strobe",   mem_rd & mem_wr,   1'b0);
    check("excl_done",     ic_done & dc_done, 1'b0);
  endtask

  // One clock: drive just after the rising edge, then sample and compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) begin
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      rstn      = ($urandom_range(299) == 0);
      if (ic_req && seen_ic_done)            ic_req = 1'b0;
      else if (!ic_req)                      ic_req = ($urandom_range(2) == 0);
      else if ($urandom_range(49) == 0)      ic_req = 1'b0;
      if ((dc_rd_req || dc_wr_req) && seen_dc_done) begin
        dc_rd_req = 1'b0; dc_wr_req = 1'b0;
      end else if (!dc_rd_req && !dc_wr_req) begin
        case ($urandom_range(5))
          0: dc_rd_req = 1'b1;
          1: dc_wr_req = 1'b1;
          2: begin dc_rd_req = 1'b1; dc_wr_req = 1'b1; end
          default: ;
        endcase
      end else if ($urandom_range(49) == 0) begin
        dc_rd_req = 1'b0; dc_wr_req = 1'b0;
      end
      ic_addr  = $urandom;
      dc_addr  = $urandom;
      dc_wdata = $urandom;
    end else if (auto_drop) begin
      if (seen_ic_done) ic_req = 1'b0;
      if (seen_dc_done) begin
        if (dc_wr_req) dc_wr_req = 1'b0;
        else           dc_rd_req = 1'b0;
      end
    end
    @(negedge clk);
    cyc++;
    seen_ic_done = ic_done;
    seen_dc_done = dc_done;
    if (ic_done) begin done_log.push_back(1'b0); ic_done_cyc = cyc; end
    if (dc_done) begin done_log.push_back(1'b1); dc_done_cyc = cyc; end
    model_compare();
  endtask

  task automatic reset_dut();
    rstn = 1'b1;
    ic_req = 1'b0; dc_rd_req = 1'b0; dc_wr_req = 1'b0;
    tick();
    tick();
    rstn = 1'b0;
  endtask

  initial begin
    int base;
    int n;
    logic [127:0] p1, p2;

    rstn = 1'b1;
    ic_req = 1'b0; ic_addr = '0;
    dc_rd_req = 1'b0; dc_wr_req = 1'b0; dc_addr = '0; dc_wdata = '0;
    mem_rdata = '0;

    // Reset state
    reset_dut();
    check("rst_mem_rd",    mem_rd,    1'b0);
    check("rst_mem_wr",    mem_wr,    1'b0);
    check("rst_mem_addr",  mem_addr,  32'd0);
    check("rst_ic_rdata",  ic_rdata,  128'd0);
    check("rst_dc_rdata",  dc_rdata,  128'd0);

    // Idle for 20 cycles
    for (int c = 0; c < 20; c++) begin
      tick();
      check("idle_strobes", {mem_rd, mem_wr}, 2'b00);
      check("idle_dones",   {ic_done, dc_done}, 2'b00);
    end

    // IC read alone
    mem_rdata = {4{32'hAAAA_AAAA}};
    ic_addr   = 32'h0000_1234;
    ic_req    = 1'b1;
    for (int c = 1; c <= LAT + 2; c++) begin
      tick();
      check("ic_rd_strobe", mem_rd, c <= LAT);
      if (c <= LAT) check("ic_rd_addr", mem_addr, 32'h0000_1230);
      check("ic_rd_done", ic_done, c == LAT + 1);
      if (c == LAT + 1) check("ic_rd_rdata", ic_rdata, {4{32'hAAAA_AAAA}});
    end

    // Simultaneous IC and DC reads after reset
    reset_dut();
    base = done_log.size();
    ic_req = 1'b1; ic_addr = $urandom;
    dc_rd_req = 1'b1; dc_addr = $urandom;
    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    repeat (2 * LAT + 6) tick();
    check("both_count", done_log.size() - base, 2);
    check("both_first_ic", done_log[base], 1'b0);
    check("both_then_dc", done_log[base + 1], 1'b1);
    check("both_gap", dc_done_cyc - ic_done_cyc, LAT + 2);

    // Write takes priority over read; write leaves dc_rdata alone
    p1 = {4{32'h1357_9BDF}};
    p2 = {$urandom, $urandom, $urandom, $urandom};
    mem_rdata = p1;
    dc_addr = 32'h0000_0080; dc_rd_req = 1'b1;
    repeat (LAT + 2) tick();
    check("pre_dc_rdata", dc_rdata, p1);
    mem_rdata = p2;
    dc_addr = 32'h0000_0040; dc_wdata = 32'hDEAD_BEEF;
    dc_wr_req = 1'b1; dc_rd_req = 1'b1;
    for (int c = 1; c <= LAT + 1; c++) begin
      tick();
      check("wr_strobe", mem_wr, c <= LAT);
      check("wr_no_rd",  mem_rd, 1'b0);
      if (c <= LAT) begin
        check("wr_addr",  mem_addr,  32'h0000_0040);
        check("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
      end
      check("wr_done", dc_done, c == LAT + 1);
      if (c == LAT + 1) check("wr_keeps_rdata", dc_rdata, p1);
    end
    repeat (LAT + 2) tick();
    check("rd_after_wr_done",  dc_done,  1'b1);
    check("rd_after_wr_rdata", dc_rdata, p2);
    check("rd_after_wr_addr",  mem_addr, 32'h0000_0040);

    // Reset during access cycle 2 aborts silently; held request restarts in full
    tick();
    base = done_log.size();
    ic_addr = 32'h0000_5678; ic_req = 1'b1;
    tick();
    tick();
    rstn = 1'b1;
    tick();
    check("abort_strobes", {mem_rd, mem_wr}, 2'b00);
    check("abort_dones",   {ic_done, dc_done}, 2'b00);
    check("abort_addr",    mem_addr,  32'd0);
    check("abort_wdata",   mem_wdata, 32'd0);
    check("abort_ic_rdata", ic_rdata, 128'd0);
    check("abort_dc_rdata", dc_rdata, 128'd0);
    rstn = 1'b0;
    for (int c = 4; c <= LAT + 5; c++) begin
      tick();
      check("restart_strobe", mem_rd, (c >= 4) && (c <= LAT + 3));
      check("restart_done",   ic_done, c == LAT + 4);
    end
    check("restart_one_done", done_log.size() - base, 1);

    // Continuous IC and DC reads alternate grants
    reset_dut();
    auto_drop = 1'b0;
    base = done_log.size();
    ic_req = 1'b1; dc_rd_req = 1'b1;
    n = 0;
    while ((done_log.size() < base + 6) && (n < 6 * (LAT + 2) + 8)) begin
      tick();
      n++;
    end
    check("alt_count", done_log.size() - base, 6);
    for (int i = 0; i < 6; i++) check("alt_order", done_log[base + i], i % 2);
    auto_drop = 1'b1;

    // Randomized traffic against the model
    reset_dut();
    rand_mode = 1'b1;
    repeat (3000) tick();
    rand_mode = 1'b0;
    rstn = 1'b0;
    ic_req = 1'b0; dc_rd_req = 1'b0; dc_wr_req = 1'b0;
    repeat (2 * LAT + 4) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
